dpram_arb: RTL and testbench

//  Port-A sequencer and arbiter for the 2^AW x DW dual-port register RAM. After reset, or on
//  clr_i, sweeps every address writing INIT. In RUN, shares RAM port A (read/write) between

---
 rtl/dpram_arb.sv | 121 ++++++++++++
 tb/tb_dpram_arb.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/dpram_arb.sv
// Port-A sequencer/arbiter for a dual-port register RAM: init sweep after reset or clear,
// then round-robin sharing of the read/write port between requesters A and B.
module dpram_arb #(
    parameter int            AW   = 5,
    parameter int            DW   = 2,
    parameter logic [DW-1:0] INIT = '0
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          ena_i,
    input  logic          clr_i,
    output logic          busy_o,
    input  logic          a_req_i,
    input  logic          a_wre_i,
    input  logic [AW-1:0] a_adr_i,
    input  logic [DW-1:0] a_dat_i,
    output logic          a_ack_o,
    output logic [DW-1:0] a_dat_o,
    input  logic          b_req_i,
    input  logic          b_wre_i,
    input  logic [AW-1:0] b_adr_i,
    input  logic [DW-1:0] b_dat_i,
    output logic          b_ack_o,
    output logic [DW-1:0] b_dat_o,
    output logic [AW-1:0] ram_adr_o,
    output logic [DW-1:0] ram_dat_o,
    output logic          ram_wre_o,
    output logic          ram_ena_o,
    input  logic [DW-1:0] ram_dat_i
);
    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [1:0] GNT_NONE = 2'd0;
    localparam logic [1:0] GNT_A    = 2'd1;
    localparam logic [1:0] GNT_B    = 2'd2;

    localparam logic [AW-1:0] CNT_MAX = {AW{1'b1}};

    logic [0:0]    state;
    logic [AW-1:0] cnt;
    logic [1:0]    gnt;
    logic [1:0]    gnt_nxt;
    logic          last;   // 0 = A served last, 1 = B served last
    logic          a_elig;
    logic          b_elig;

    assign busy_o    = (state == ST_INIT);
    assign ram_ena_o = ena_i;
    assign a_ack_o   = ena_i && (gnt == GNT_A);
    assign b_ack_o   = ena_i && (gnt == GNT_B);
    assign a_dat_o   = ram_dat_i;
    assign b_dat_o   = ram_dat_i;

    // A requester being acked this cycle is not eligible, so a lone holder
    // gets every other cycle while two busy requesters alternate back-to-back.
    assign a_elig = a_req_i && (gnt != GNT_A);
    assign b_elig = b_req_i && (gnt != GNT_B);

    always_comb begin
        gnt_nxt = GNT_NONE;
        if (a_elig && b_elig)
            gnt_nxt = last ? GNT_A : GNT_B;
        else if (a_elig)
            gnt_nxt = GNT_A;
        else if (b_elig)
            gnt_nxt = GNT_B;
    end

    always_comb begin
        ram_adr_o = '0;
        ram_dat_o = INIT;
        ram_wre_o = 1'b0;
        if (state == ST_INIT) begin
            ram_adr_o = cnt;
            ram_wre_o = 1'b1;
        end else if (gnt == GNT_A) begin
            ram_adr_o = a_adr_i;
            ram_dat_o = a_dat_i;
            ram_wre_o = a_wre_i;
        end else if (gnt == GNT_B) begin
            ram_adr_o = b_adr_i;
            ram_dat_o = b_dat_i;
            ram_wre_o = b_wre_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= ST_INIT;
            cnt   <= '0;
            gnt   <= GNT_NONE;
            last  <= 1'b1;
        end else if (ena_i) begin
            if (gnt == GNT_A)
                last <= 1'b0;
            else if (gnt == GNT_B)
                last <= 1'b1;

            if (state == ST_INIT) begin
                gnt <= GNT_NONE;
                if (clr_i) begin
                    cnt <= '0;
                end else if (cnt == CNT_MAX) begin
                    state <= ST_RUN;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else if (clr_i) begin
                // a grant that would be issued at this edge is dropped; its
                // requester still holds req and is picked up after the sweep
                state <= ST_INIT;
                cnt   <= '0;
                gnt   <= GNT_NONE;
            end else begin
                gnt <= gnt_nxt;
            end
        end
    end
endmodule

// File: tb/tb_dpram_arb.sv
// Directed bench for dpram_arb with a behavioural 32x2 register RAM on port A.
module tb_dpram_arb;
    logic       clk_i = 1'b0;
    logic       rst_i, ena_i, clr_i, busy_o;
    logic       a_req_i, a_wre_i, a_ack_o;
    logic [4:0] a_adr_i;
    logic [1:0] a_dat_i, a_dat_o;
    logic       b_req_i, b_wre_i, b_ack_o;
    logic [4:0] b_adr_i;
    logic [1:0] b_dat_i, b_dat_o;
    logic [4:0] ram_adr_o;
    logic [1:0] ram_dat_o, ram_dat_i;
    logic       ram_wre_o, ram_ena_o;

    logic [1:0] mem [32];
    logic       fill;
    int         total = 0;
    int         bad   = 0;

    always #5 clk_i = ~clk_i;

    dpram_arb dut (
        .clk_i(clk_i), .rst_i(rst_i), .ena_i(ena_i), .clr_i(clr_i), .busy_o(busy_o),
        .a_req_i(a_req_i), .a_wre_i(a_wre_i), .a_adr_i(a_adr_i), .a_dat_i(a_dat_i),
        .a_ack_o(a_ack_o), .a_dat_o(a_dat_o),
        .b_req_i(b_req_i), .b_wre_i(b_wre_i), .b_adr_i(b_adr_i), .b_dat_i(b_dat_i),
        .b_ack_o(b_ack_o), .b_dat_o(b_dat_o),
        .ram_adr_o(ram_adr_o), .ram_dat_o(ram_dat_o), .ram_wre_o(ram_wre_o),
        .ram_ena_o(ram_ena_o), .ram_dat_i(ram_dat_i)
    );

    // register RAM: combinational read, write on posedge; fill preloads garbage
    always @(posedge clk_i) begin
        if (fill) begin
            for (int k = 0; k < 32; k++) mem[k] <= 2'b11;
        end else if (ram_ena_o && ram_wre_o) begin
            mem[ram_adr_o] <= ram_dat_o;
        end
    end
    assign ram_dat_i = mem[ram_adr_o];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // counts busy cycles until RUN, bounded at 100
    task automatic sweep_len(output int n);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            if (!busy_o) break;
            n++;
            tick();
        end
    endtask

    initial begin
        int         n, en, err, nz;
        logic [7:0] pat;
        logic [3:0] pat4;

        rst_i = 1'b0; ena_i = 1'b1; clr_i = 1'b0; fill = 1'b1;
        a_req_i = 1'b0; a_wre_i = 1'b0; a_adr_i = '0; a_dat_i = '0;
        b_req_i = 1'b0; b_wre_i = 1'b0; b_adr_i = '0; b_dat_i = '0;
        tick();
        fill = 1'b0;
        // reset state
        chk("rst_busy", busy_o, 1);
        chk("rst_acks", {a_ack_o, b_ack_o}, 2'b00);
        chk("rst_adr", ram_adr_o, 0);
        chk("rst_wre", ram_wre_o, 1);
        chk("rst_dat", ram_dat_o, 0);
        tick();

        // 1: init sweep
        rst_i = 1'b1;
        #1;
        sweep_len(n);
        chk("sweep_len", n, 32);
        chk("sweep_busy_low", busy_o, 0);
        nz = 0;
        for (int k = 0; k < 32; k++) if (mem[k] !== 2'b00) nz++;
        chk("sweep_clean", nz, 0);

        // 3: both requesters continuous, A first
        a_req_i = 1'b1; a_wre_i = 1'b0; a_adr_i = 5'd5;
        b_req_i = 1'b1; b_wre_i = 1'b0; b_adr_i = 5'd6;
        #1;
        chk("rr_no_ack_first", {a_ack_o, b_ack_o}, 2'b00);
        pat = '0;
        for (int c = 0; c < 4; c++) begin
            tick();
            pat = {pat[5:0], a_ack_o, b_ack_o};
        end
        chk("rr_pattern", pat, 8'b10011001);
        a_req_i = 1'b0; b_req_i = 1'b0;
        tick();
        chk("rr_idle", {a_ack_o, b_ack_o}, 2'b00);

        // 2: A write adr 5 = 3, then A read back
        a_req_i = 1'b1; a_wre_i = 1'b1; a_adr_i = 5'd5; a_dat_i = 2'b11;
        #1;
        chk("wr_no_ack_yet", a_ack_o, 0);
        tick();
        chk("wr_ack", a_ack_o, 1);
        chk("wr_ram_adr", ram_adr_o, 5);
        chk("wr_ram_wre", ram_wre_o, 1);
        a_req_i = 1'b0;
        tick();
        a_req_i = 1'b1; a_wre_i = 1'b0;
        #1;
        chk("rd_no_ack_yet", a_ack_o, 0);
        tick();
        chk("rd_dat", a_dat_o, 2'b11);
        // lone holder: every other cycle
        pat4 = '0;
        for (int c = 0; c < 4; c++) begin
            pat4 = {pat4[2:0], a_ack_o};
            if (c < 3) tick();
        end
        chk("lone_pattern", pat4, 4'b1010);
        a_req_i = 1'b0;
        tick();

        // 4: ena_i low during a grant
        a_req_i = 1'b1; a_wre_i = 1'b1; a_adr_i = 5'd7; a_dat_i = 2'b01;
        tick();
        ena_i = 1'b0;
        #1;
        err = 0;
        for (int c = 0; c < 3; c++) begin
            if (a_ack_o !== 1'b0 || ram_ena_o !== 1'b0) err++;
            if (c < 2) tick();
        end
        chk("freeze_no_ack", err, 0);
        tick();
        ena_i = 1'b1;
        #1;
        chk("freeze_resume_ack", a_ack_o, 1);
        chk("freeze_resume_adr", ram_adr_o, 7);
        a_req_i = 1'b0;
        tick();
        b_req_i = 1'b1; b_wre_i = 1'b0; b_adr_i = 5'd7;
        tick();
        chk("b_read_ack", b_ack_o, 1);
        chk("b_read_dat", b_dat_o, 2'b01);
        b_req_i = 1'b0;
        tick();

        // 5: clr_i while a B grant is pending, with a 3-cycle freeze mid-sweep
        b_req_i = 1'b1; b_adr_i = 5'd7; clr_i = 1'b1;
        #1;
        chk("clr_no_ack", b_ack_o, 0);
        tick();
        clr_i = 1'b0;
        en = 0; err = 0;
        for (int i = 0; i < 100; i++) begin
            ena_i = (i >= 10 && i < 13) ? 1'b0 : 1'b1;
            #1;
            if (!busy_o) break;
            if (ram_adr_o !== en[4:0]) err++;
            if (b_ack_o !== 1'b0) err++;
            if (ena_i) en++;
            tick();
        end
        chk("clr_sweep_len", en, 32);
        chk("clr_sweep_err", err, 0);
        chk("clr_first_run_no_ack", b_ack_o, 0);
        tick();
        chk("clr_b_served", b_ack_o, 1);
        chk("clr_b_dat", b_dat_o, 2'b00);
        b_req_i = 1'b0;
        tick();

        // 6: reset during an A write ack
        a_req_i = 1'b1; a_wre_i = 1'b1; a_adr_i = 5'd9; a_dat_i = 2'b10;
        tick();
        chk("rstmid_ack", a_ack_o, 1);
        rst_i = 1'b0;
        #1;
        chk("rstmid_ack_drop", a_ack_o, 0);
        chk("rstmid_busy", busy_o, 1);
        a_req_i = 1'b0;
        tick();
        rst_i = 1'b1;
        #1;
        sweep_len(n);
        chk("rstmid_sweep_len", n, 32);
        b_req_i = 1'b1; b_wre_i = 1'b0; b_adr_i = 5'd9;
        tick();
        chk("rstmid_b_ack", b_ack_o, 1);
        chk("rstmid_entry_init", b_dat_o, 2'b00);
        b_req_i = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
